board_input_debounce: RTL and testbench

Front-panel input reader for the Catapult v3 board: the input-side counterpart to the LED output driver. Samples up to WIDTH asynchronous board inputs (push-buttons, jumpers, strap pins), synchronizes and debounces each one, and exposes clean levels, one-cycle edge pulses, and a valid/ack event port. Runs in the `clk_u59` domain, alongside the LED logic.

---
 rtl/board_io_pkg.sv | 12 +
 rtl/debounce_channel.sv | 80 ++++++++
 rtl/board_input_debounce.sv | 82 ++++++++
 tb/tb_board_input_debounce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared types and default constants for the board front-panel input reader.
package board_io_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } deb_state_t;

  localparam int BOARD_IN_WIDTH       = 9;
  localparam int DEBOUNCE_100MHZ_10MS = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, STABLE/CHECK debounce FSM and counter.
// commit is combinational so the top can set pending on the same edge level toggles.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS
) (
  input  logic clk_u59,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta, sync;
  deb_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  always_ff @(posedge clk_u59 or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  always_ff @(posedge clk_u59 or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level ^ commit;
      rise  <= commit & ~level;
      fall  <= commit & level;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      STABLE: begin
        if (sync != level) begin
          state_d = CHECK;
          cnt_d   = CW'(1);
        end
      end
      CHECK: begin
        if (sync == level) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          commit  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/board_input_debounce.sv
// Debounced board inputs with edge pulses and a valid/ack event port.
// Pending bits are drained lowest index first; a commit on a still-pending channel loses the older event.
module board_input_debounce
  import board_io_pkg::*;
#(
  parameter  int WIDTH           = BOARD_IN_WIDTH,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  localparam int IW              = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_u59,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             event_valid,
  output logic [IW-1:0]    event_idx,
  output logic             event_level,
  input  logic             event_ack,
  output logic             overrun,
  input  logic             overrun_clr
);

  logic [WIDTH-1:0] commit_vec;
  logic [WIDTH-1:0] pending, pending_d, ack_mask;
  logic             ack_fire, ovr_hit, any_pending;
  logic [IW-1:0]    first_idx;
  logic             first_lvl;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk_u59 (clk_u59),
      .rst_n   (rst_n),
      .pin     (pins[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .commit  (commit_vec[i])
    );
  end

  // Priority encoder: scan downward so the lowest pending index wins.
  always_comb begin
    first_idx = '0;
    first_lvl = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        first_idx = IW'(i);
        first_lvl = level[i];
      end
    end
  end

  always_comb begin
    ack_fire = event_valid & event_ack;
    for (int i = 0; i < WIDTH; i++) ack_mask[i] = ack_fire && (event_idx == IW'(i));
    any_pending = |pending;
    ovr_hit     = |(commit_vec & pending & ~ack_mask);
    pending_d   = (pending & ~ack_mask) | commit_vec;
  end

  always_ff @(posedge clk_u59 or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      overrun     <= 1'b0;
      event_valid <= 1'b0;
      event_idx   <= '0;
      event_level <= 1'b0;
    end else begin
      pending <= pending_d;
      overrun <= ovr_hit | (overrun & ~overrun_clr);
      if (event_valid) begin
        if (event_ack) event_valid <= 1'b0;
      end else if (any_pending) begin
        event_valid <= 1'b1;
        event_idx   <= first_idx;
        event_level <= first_lvl;
      end
    end
  end

endmodule

// File: tb/tb_board_input_debounce.sv
// Directed self-checking bench for board_input_debounce (WIDTH=9, DEBOUNCE_CYCLES=4).
module tb_board_input_debounce;

  logic       clk_u59 = 1'b0;
  logic       rst_n;
  logic [8:0] pins;
  logic [8:0] level, rise, fall;
  logic       event_valid, event_level, event_ack, overrun, overrun_clr;
  logic [3:0] event_idx;

  int n_chk  = 0;
  int n_fail = 0;

  board_input_debounce #(.WIDTH(9), .DEBOUNCE_CYCLES(4)) dut (
    .clk_u59     (clk_u59),
    .rst_n       (rst_n),
    .pins        (pins),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .event_valid (event_valid),
    .event_idx   (event_idx),
    .event_level (event_level),
    .event_ack   (event_ack),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk_u59 = ~clk_u59;

  typedef struct {
    logic [8:0] pins;
    logic       ack;
    logic [8:0] lvl, rs, fl;
    logic       vld;
    logic [3:0] idx;
    logic       evl;
    logic       ovr;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [8:0] p, input logic a, input logic [8:0] l, r, f,
                              input logic v, input logic [3:0] ix, input logic el, input logic o);
    vec_t t;
    t.pins = p; t.ack = a; t.lvl = l; t.rs = r; t.fl = f;
    t.vld = v; t.idx = ix; t.evl = el; t.ovr = o;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk_u59);
    #1;
  endtask

  // idx/evl are only meaningful while an event is presented.
  task automatic expect_out(input string name, input logic [8:0] l, r, f, input logic v,
                            input logic [3:0] ix, input logic el, input logic o);
    logic [33:0] act, exp;
    act = {level, rise, fall, event_valid, overrun, v ? event_idx : 4'd0, v ? event_level : 1'b0};
    exp = {l, r, f, v, o, v ? ix : 4'd0, v ? el : 1'b0};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lvl=%h rise=%h fall=%h vld=%b ovr=%b idx=%0d evl=%b, expected lvl=%h rise=%h fall=%h vld=%b ovr=%b idx=%0d evl=%b",
               name, level, rise, fall, event_valid, overrun, event_idx, event_level,
               l, r, f, v, o, ix, el);
    end
  endtask

  initial begin
    rst_n = 1'b0; pins = '0; event_ack = 1'b0; overrun_clr = 1'b0;
    repeat (2) tick();
    expect_out("reset", 9'h0, 9'h0, 9'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Clean step on pin 3, then a 3-sample glitch on pin 0.
    for (int i = 0; i < 5; i++) tbl[i] = mk(9'h008, 0, 9'h000, 9'h000, 9'h0, 0, 4'd0, 0, 0);
    tbl[5] = mk(9'h008, 0, 9'h008, 9'h008, 9'h0, 0, 4'd0, 0, 0);
    tbl[6] = mk(9'h008, 0, 9'h008, 9'h000, 9'h0, 1, 4'd3, 1, 0);
    tbl[7] = mk(9'h008, 1, 9'h008, 9'h000, 9'h0, 0, 4'd0, 0, 0);
    tbl[8] = mk(9'h008, 0, 9'h008, 9'h000, 9'h0, 0, 4'd0, 0, 0);
    for (int i = 9; i < 12; i++)  tbl[i] = mk(9'h009, 0, 9'h008, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    for (int i = 12; i < 17; i++) tbl[i] = mk(9'h008, 0, 9'h008, 9'h0, 9'h0, 0, 4'd0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      pins = tbl[i].pins;
      event_ack = tbl[i].ack;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].rs, tbl[i].fl, tbl[i].vld,
                 tbl[i].idx, tbl[i].evl, tbl[i].ovr);
    end
    event_ack = 1'b0;

    // Simultaneous commits on pins 1 and 7, drained in index order.
    pins = 9'h08A;
    repeat (5) tick();
    expect_out("sim_pre", 9'h008, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("sim_commit", 9'h08A, 9'h082, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("sim_ev1", 9'h08A, 9'h0, 9'h0, 1, 4'd1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out("sim_hold", 9'h08A, 9'h0, 9'h0, 1, 4'd1, 1, 0);
    end
    event_ack = 1'b1; tick(); event_ack = 1'b0;
    expect_out("sim_ack1", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("sim_ev7", 9'h08A, 9'h0, 9'h0, 1, 4'd7, 1, 0);
    event_ack = 1'b1; tick(); event_ack = 1'b0;
    expect_out("sim_ack7", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    repeat (2) tick();
    expect_out("sim_drained", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 0);

    // Overrun: pin 2 up then down while its event is never acked.
    pins = 9'h08E;
    repeat (6) tick();
    expect_out("ovr_up", 9'h08E, 9'h004, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("ovr_ev", 9'h08E, 9'h0, 9'h0, 1, 4'd2, 1, 0);
    pins = 9'h08A;
    repeat (5) tick();
    expect_out("ovr_pre", 9'h08E, 9'h0, 9'h0, 1, 4'd2, 1, 0);
    tick();
    expect_out("ovr_set", 9'h08A, 9'h0, 9'h004, 1, 4'd2, 1, 1);
    tick();
    expect_out("ovr_hold", 9'h08A, 9'h0, 9'h0, 1, 4'd2, 1, 1);
    event_ack = 1'b1; tick(); event_ack = 1'b0;
    expect_out("ovr_ack", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 1);
    tick();
    expect_out("ovr_lost", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    expect_out("ovr_clr", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 0);

    // Commit on the presented channel in the same cycle as its ack.
    pins = 9'h08E;
    repeat (6) tick();
    expect_out("col_up", 9'h08E, 9'h004, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("col_ev1", 9'h08E, 9'h0, 9'h0, 1, 4'd2, 1, 0);
    pins = 9'h08A;
    repeat (5) tick();
    event_ack = 1'b1; tick(); event_ack = 1'b0;
    expect_out("col_commit", 9'h08A, 9'h0, 9'h004, 0, 4'd0, 0, 0);
    tick();
    expect_out("col_ev2", 9'h08A, 9'h0, 9'h0, 1, 4'd2, 0, 0);
    event_ack = 1'b1; tick(); event_ack = 1'b0;
    expect_out("col_ack2", 9'h08A, 9'h0, 9'h0, 0, 4'd0, 0, 0);

    // Reset with pin 0 in CHECK and an event presented.
    pins = 9'h08E;
    repeat (7) tick();
    expect_out("rst_ev", 9'h08E, 9'h0, 9'h0, 1, 4'd2, 1, 0);
    pins = 9'h08F;
    repeat (3) tick();
    expect_out("rst_pre", 9'h08E, 9'h0, 9'h0, 1, 4'd2, 1, 0);
    #2 rst_n = 1'b0;
    #1 expect_out("rst_async", 9'h0, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    pins = 9'h1FF;
    @(posedge clk_u59); #1;
    rst_n = 1'b1;
    repeat (5) tick();
    expect_out("rst_wait", 9'h0, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    tick();
    expect_out("rst_commit", 9'h1FF, 9'h1FF, 9'h0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      expect_out($sformatf("drain_ev%0d", i), 9'h1FF, 9'h0, 9'h0, 1, 4'(i), 1, 0);
      event_ack = 1'b1; tick(); event_ack = 1'b0;
      expect_out($sformatf("drain_ack%0d", i), 9'h1FF, 9'h0, 9'h0, 0, 4'd0, 0, 0);
    end
    tick();
    expect_out("drain_done", 9'h1FF, 9'h0, 9'h0, 0, 4'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
